// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: multi-digit 7-seg scanner with hex or double-dabble decimal display.
module seven_seg_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              mode_i,
  input  logic              blank_lz_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic [DIGITS-1:0] dp_in_i,
  output logic              busy_o,
  output logic [7:0]        cathodes_o,
  output logic [DIGITS-1:0] anodes_o
);
  localparam int BCD_D = (DATA_W + 2) / 3;
  localparam int BW    = 4 * BCD_D;
  localparam int DW    = 4 * DIGITS;
  localparam int IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int RW    = $clog2(REFRESH_DIV);
  localparam int CW    = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic              ovf_q, ovf_d, blz_q, blz_d, pblz_q, pblz_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj, bcd_nx;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     ref_q, ref_d;
  logic [IW-1:0]     dig_q, dig_d;
  logic [7:0]        cath_q, cath_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    blz_d   = blz_q;
    pblz_d  = pblz_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int k = 0; k < BCD_D; k++)
      if (bcd_q[4*k +: 4] > 4'd4) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    bcd_nx = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
    if (state_q == IDLE && load_i) begin
      if (mode_i) begin
        state_d = CONV;
        sh_d    = data_in_i;
        bcd_d   = '0;
        cnt_d   = '0;
        pblz_d  = blank_lz_i;
      end else begin
        disp_d = DW'(data_in_i);
        ovf_d  = 1'b0;
        blz_d  = blank_lz_i;
      end
    end else if (state_q == CONV) begin
      sh_d  = sh_q << 1;
      bcd_d = bcd_nx;
      cnt_d = cnt_q + CW'(1);
      // The final iteration commits its own result, so the display updates on that same edge.
      if (cnt_q == CW'(DATA_W - 1)) begin
        state_d = IDLE;
        disp_d  = DW'(bcd_nx);
        ovf_d   = |(bcd_nx >> DW);
        blz_d   = pblz_q;
      end
    end
  end

  always_comb begin
    ref_d  = ref_q == RW'(REFRESH_DIV - 1) ? '0 : ref_q + RW'(1);
    dig_d  = ref_q != RW'(REFRESH_DIV - 1) ? dig_q :
             dig_q == IW'(DIGITS - 1) ? '0 : dig_q + IW'(1);
    nib    = 4'(disp_q >> {dig_q, 2'b00});
    blank  = blz_q && dig_q != '0 && (disp_q >> {dig_q, 2'b00}) == '0;
    seg    = ovf_q ? 7'h3F : blank ? 7'h7F : glyph(nib);
    cath_d = {~dp_in_i[dig_q], seg};
    an_d   = ~(DIGITS'(1) << dig_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      blz_q   <= 1'b0;
      pblz_q  <= 1'b0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      dig_q   <= '0;
      cath_q  <= 8'hFF;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      blz_q   <= blz_d;
      pblz_q  <= pblz_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
      cath_q  <= cath_d;
      an_q    <= an_d;
    end
  end

  assign busy_o     = state_q == CONV;
  assign cathodes_o = cath_q;
  assign anodes_o   = an_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: randomized checks of the scan controller against an arithmetic display model.
module tb_seven_seg_scan_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, mode = 1'b0, blz = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        busy;
  logic [7:0]  cathodes_o;
  logic [3:0]  anodes_o;
  int          total = 0, bad = 0;
  logic [7:0]  frame [4];
  logic [3:0]  seen;
  int          bad_an;
  logic [7:0]  glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          p10 [4] = '{1, 10, 100, 1000};

  seven_seg_scan_ctrl #(.DIGITS(4), .DATA_W(16), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .mode_i(mode), .blank_lz_i(blz),
    .data_in_i(data), .dp_in_i(dp), .busy_o(busy), .cathodes_o(cathodes_o), .anodes_o(anodes_o));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [7:0] exp_seg(input int v, input bit m, input bit b, input logic [3:0] d, input int i);
    int hi;
    logic [7:0] g;
    if (m && v > 9999) g = 8'hBF;
    else begin
      hi = m ? v / p10[i] : v >> (4 * i);
      g  = (b && i != 0 && hi == 0) ? 8'hFF : glyph_tbl[m ? hi % 10 : hi % 16];
    end
    return {~d[i], g[6:0]};
  endfunction

  task automatic do_load(input logic [15:0] v, input bit m, input bit b);
    @(negedge clk);
    data = v; mode = m; blz = b; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    data = 16'($urandom); mode = 1'($urandom); blz = 1'($urandom);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic grab();
    bit found;
    seen = '0;
    bad_an = 0;
    @(posedge clk);
    repeat (20) begin
      @(negedge clk);
      found = 0;
      for (int k = 0; k < 4; k++)
        if (anodes_o == ~(4'b1 << k)) begin
          frame[k] = cathodes_o;
          seen[k] = 1'b1;
          found = 1;
        end
      if (!found) bad_an++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea;
    repeat (3) @(negedge clk);
    total++;
    if (anodes_o !== 4'hF || cathodes_o !== 8'hFF || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state an=%h cath=%h busy=%b exp an=F cath=FF busy=0", anodes_o, cathodes_o, busy);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ea = ~(4'b1 << ((k / 4) % 4));
      total++;
      if (anodes_o !== ea || cathodes_o !== 8'hC0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_scan k=%0d an=%h cath=%h busy=%b exp an=%h cath=C0 busy=0", k, anodes_o, cathodes_o, busy, ea);
      end
    end
  endtask

  task automatic test_hex();
    int n;
    do_load(16'hA5F0, 1'b0, 1'b0);
    wait_idle(n);
    total++;
    if (n != 0) begin bad++; $display("FAIL hex_busy cycles=%0d exp=0", n); end
    grab();
    total++;
    if (seen !== 4'hF || bad_an != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL hex_scan seen=%h bad_an=%0d busy=%b exp seen=F bad_an=0 busy=0", seen, bad_an, busy);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame[i] !== exp_seg(16'hA5F0, 0, 0, dp, i)) begin
        bad++; $display("FAIL hex_digit%0d got=%h exp=%h", i, frame[i], exp_seg(16'hA5F0, 0, 0, dp, i));
      end
    end
  endtask

  task automatic test_decimal(input int v, input bit b);
    int n;
    do_load(16'(v), 1'b1, b);
    wait_idle(n);
    total++;
    if (n != 16) begin bad++; $display("FAIL dec_busy v=%0d cycles=%0d exp=16", v, n); end
    grab();
    total++;
    if (seen !== 4'hF || bad_an != 0) begin
      bad++; $display("FAIL dec_scan seen=%h bad_an=%0d exp seen=F bad_an=0", seen, bad_an);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame[i] !== exp_seg(v, 1, b, dp, i)) begin
        bad++; $display("FAIL dec_digit%0d v=%0d got=%h exp=%h", i, v, frame[i], exp_seg(v, 1, b, dp, i));
      end
    end
  endtask

  task automatic test_busy();
    int n;
    do_load(16'd1234, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    data = 16'd42; mode = 1'b0; blz = 1'b1; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_idle(n);
    total++;
    if (n == 0 || n >= 100) begin bad++; $display("FAIL busy_len cycles=%0d exp=12", n); end
    dp = 4'b0100;
    grab();
    total++;
    if (seen !== 4'hF || bad_an != 0) begin
      bad++; $display("FAIL busy_scan seen=%h bad_an=%0d exp seen=F bad_an=0", seen, bad_an);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame[i] !== exp_seg(1234, 1, 0, 4'b0100, i)) begin
        bad++; $display("FAIL busy_digit%0d got=%h exp=%h", i, frame[i], exp_seg(1234, 1, 0, 4'b0100, i));
      end
    end
    dp = 4'b0000;
  endtask

  task automatic test_random();
    int n, v;
    bit m, b;
    for (int t = 0; t < 12; t++) begin
      v = $urandom_range(0, 1) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 65535));
      m = 1'($urandom);
      b = 1'($urandom);
      dp = 4'($urandom);
      do_load(16'(v), m, b);
      wait_idle(n);
      total++;
      if (n != (m ? 16 : 0)) begin bad++; $display("FAIL rnd_busy t=%0d cycles=%0d exp=%0d", t, n, m ? 16 : 0); end
      grab();
      for (int i = 0; i < 4; i++) begin
        total++;
        if (frame[i] !== exp_seg(v, m, b, dp, i) || !seen[i]) begin
          bad++; $display("FAIL rnd_digit%0d t=%0d v=%0d m=%0d b=%0d got=%h exp=%h", i, t, v, m, b, frame[i], exp_seg(v, m, b, dp, i));
        end
      end
    end
    dp = 4'b0000;
  endtask

  task automatic test_reset_mid();
    do_load(16'd1234, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || anodes_o !== 4'hF || cathodes_o !== 8'hFF) begin
      bad++; $display("FAIL midrst_state busy=%b an=%h cath=%h exp busy=0 an=F cath=FF", busy, anodes_o, cathodes_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    grab();
    total++;
    if (seen !== 4'hF || bad_an != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_scan seen=%h bad_an=%0d busy=%b exp seen=F bad_an=0 busy=0", seen, bad_an, busy);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame[i] !== exp_seg(0, 0, 0, 4'b0000, i)) begin
        bad++; $display("FAIL midrst_digit%0d got=%h exp=%h", i, frame[i], exp_seg(0, 0, 0, 4'b0000, i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal(1234, 1'b1);
    test_decimal(7, 1'b1);
    test_decimal(65535, 1'b0);
    test_decimal(9999, 1'b1);
    test_busy();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Parametrised multi-digit seven-segment scan controller: the successor to the fixed 4-digit hex/BCD display path. It captures a binary value on a load strobe and shows it in hex or in decimal. Decimal conversion is a sequential double-dabble run, with overflow indication, leading-zero blanking and per-digit decimal points. The block sits between the register-mapped display port and the board pins, and owns the anode scan timing.

## Interface
- DIGITS, default 4: number of digits; ANODES width.
- DATA_W, default 16: input value width; constraint 1 ≤ DATA_W ≤ 4*DIGITS.
- REFRESH_DIV, default 100000: clocks per digit dwell; must be ≥ 2.
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- LOAD  in  1  one-cycle capture strobe; ignored while BUSY=1.
- MODE  in  1  sampled with LOAD; 0 = hex, 1 = decimal.
- BLANK_LZ  in  1  sampled with LOAD; 1 = blank leading zeros.
- DATA_IN  in  DATA_W  unsigned value, sampled with LOAD.
- DP_IN  in  DIGITS  decimal-point enables, bit i = digit i; live, not captured.
- BUSY  out  1  decimal conversion in progress.
- CATHODES  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
- ANODES  out  DIGITS  active-low digit enables, one-hot-low, registered.

## Operation
- Internal BCD width: BCD_D = (DATA_W+2)/3 digits, which is always enough for the full value.
- States: IDLE, CONV.
- IDLE with LOAD=1 and MODE=0:
  - Display register nibble i = DATA_IN[4i+3:4i], zero-extended.
  - Captured BLANK_LZ stored; state stays IDLE.
- IDLE with LOAD=1 and MODE=1:
  - Load the shift register with DATA_IN and clear the BCD accumulator.
  - Go to CONV with an iteration counter of 0.
- CONV, one double-dabble iteration per clock:
  - Add 3 to each BCD digit that is ≥ 5.
  - Then shift {BCD,bin} left by 1.
  - After DATA_W iterations: commit the result to the display register and return to IDLE.
- Overflow (decimal only): any BCD digit at index ≥ DIGITS is nonzero at commit. The overflow flag is stored; all digits then show a dash (g only).
- The display register and flags only change at a commit. Old content is shown until then (no tearing).
- LOAD while BUSY=1: ignored entirely, with no queueing.
- Scan:
  - A refresh counter runs 0..REFRESH_DIV-1.
  - At terminal count the digit index advances i → (i+1) mod DIGITS, from 0 upward.
- Digit i output:
  - ANODES has only bit i low.
  - Segments come from the display nibble (hex glyphs 0-F), a dash on overflow, or blank (all segments off).
  - dp = ~DP_IN[i], for every digit including blanked ones.
- Blanking: digit i is blank if BLANK_LZ=1, i ≠ 0, and nibble i and all higher nibbles are zero. Digit 0 is never blanked.
- Glyph codes with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E, dash=BF, blank=FF.

## Timing
- Reset values:
  - CATHODES = 8'hFF, ANODES = all ones, BUSY = 0.
  - Display register = 0, overflow = 0, BLANK_LZ flag = 0.
  - Refresh counter = 0, digit index = 0, state = IDLE.
- First anode drive is on the first clock edge after RST_N deasserts.
- Hex load: LOAD sampled at edge N, display register valid after edge N. This is a 1-clock capture latency.
- Decimal load:
  - LOAD sampled at edge N; BUSY = 1 after edge N.
  - Iterations run at edges N+1..N+DATA_W.
  - Commit and BUSY = 0 happen after edge N+DATA_W.
  - A new LOAD is accepted at edge N+DATA_W+1.
- Outputs are registered one cycle behind the digit index and display register. A new value appears on the pins at the edge after commit, for the currently selected digit.
- ANODES change exactly every REFRESH_DIV clocks, and there is never more than one low bit.
- RST_N asserted mid-conversion aborts immediately: BUSY = 0 and the display clears, asynchronously.
- MODE, BLANK_LZ and DATA_IN changes outside the LOAD cycle have no effect.
- DP_IN takes effect on the next output register update.

## Test plan
- Reset, then release with REFRESH_DIV=4 and DIGITS=4:
  - ANODES cycles E,D,B,7, each held 4 clocks.
  - CATHODES = C0 on every digit.
  - BUSY = 0.
- Hex load, LOAD with MODE=0 and DATA_IN=16'hA5F0:
  - Digits 3..0 show 88,92,8E,C0.
  - BUSY never rises.
- Decimal load, LOAD with MODE=1, DATA_IN=1234 and BLANK_LZ=1:
  - BUSY is high for exactly 16 clocks.
  - Digits 3..0 then show F9,A4,B0,99.
  - Repeat with DATA_IN=7: digits 3..1 show FF, digit 0 shows F8.
- Decimal overflow, MODE=1 with DATA_IN=65535 at DIGITS=4: after commit all digits show BF.
- Busy handling:
  - A second LOAD during BUSY is ignored; the first result is displayed.
  - DP_IN=4'b0100 clears bit 7 on digit 2 only.
- Reset mid-operation: RST_N pulsed low at conversion iteration 5. BUSY drops immediately and the display returns to C0, with anodes and cathodes at reset values during reset.
